tdm_voice_mixer: RTL

Downstream stage of the TDM wavetable BRAM interface. It consumes one time-multiplexed voice sample per `sys_clk` cycle, along with that sample's channel tag and enable flag. It scales each sample by a per-channel volume and sums all channels of one TDM frame. Once per frame it emits a single mixed sample, with a one-cycle valid strobe, to the output (PWM/DAC) stage.

---
 rtl/tdm_voice_mixer_pkg.sv | 39 +++
 rtl/tdm_voice_mixer_if.sv | 26 ++
 rtl/tdm_vol_regfile.sv | 29 ++
 rtl/tdm_voice_mixer.sv | 93 +++++++++
 4 files changed

// File: rtl/tdm_voice_mixer_pkg.sv
// Shared widths, derived constants and pipeline record types for the TDM voice mixer.
package synth_pkg;

  localparam int D_W       = 16;                  // sample width (unsigned)
  localparam int CHANNELS  = 4;                   // voices per TDM frame
  localparam int CH_BITS   = 2;                   // channel tag width
  localparam int VOL_W     = 8;                   // per-channel volume width
  localparam int PROD_W    = D_W + VOL_W;         // sample * volume
  localparam int ACC_W     = D_W + VOL_W + CH_BITS;
  localparam int MIX_SHAMT = VOL_W + CH_BITS;     // renormalise the frame sum

  typedef logic [CH_BITS-1:0] ch_t;
  typedef logic [D_W-1:0]     sample_t;
  typedef logic [VOL_W-1:0]   vol_t;
  typedef logic [PROD_W-1:0]  prod_t;
  typedef logic [ACC_W-1:0]   acc_t;

  // S1: captured slot plus the volume looked up for its channel.
  typedef struct packed {
    logic    vld;     // a slot has been captured since reset
    logic    en;
    ch_t     ch;
    sample_t sample;
    vol_t    vol;
  } s1_t;

  // S2: scaled product, already zero for disabled slots.
  typedef struct packed {
    logic  vld;
    ch_t   ch;
    prod_t prod;
  } s2_t;

  // Last tag of a frame closes the accumulation.
  function automatic logic is_last_ch(input ch_t ch);
    return ch == ch_t'(CHANNELS - 1);
  endfunction

endpackage

// File: rtl/tdm_voice_mixer_if.sv
// Slot stream, volume write port and mixed output of the TDM voice mixer.
interface tdm_voice_mixer_if;
  import synth_pkg::*;

  sample_t sample_in;
  logic    ch_en_in;
  ch_t     ch_num_in;
  logic    vol_we;
  ch_t     vol_addr;
  vol_t    vol_data;
  sample_t mix_out;
  logic    mix_valid;

  // Upstream stage and volume controller side.
  modport master (
    output sample_in, ch_en_in, ch_num_in, vol_we, vol_addr, vol_data,
    input  mix_out, mix_valid
  );

  // Mixer side.
  modport slave (
    input  sample_in, ch_en_in, ch_num_in, vol_we, vol_addr, vol_data,
    output mix_out, mix_valid
  );

endinterface

// File: rtl/tdm_vol_regfile.sv
// Per-channel volume registers: synchronous write, combinational read.
module tdm_vol_regfile
  import synth_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic we,
  input  ch_t  waddr,
  input  vol_t wdata,
  input  ch_t  raddr,
  output vol_t rdata
);

  vol_t vol_q [CHANNELS];

  // Commit volume writes; every channel powers up muted.
  // NOTE: this is a handful of flops, not a RAM, so resetting every entry is cheap and keeps all voices silent until software sets a level.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < CHANNELS; i++) vol_q[i] <= '0;
    end else if (we) begin
      vol_q[waddr] <= wdata;
    end
  end

  // A read at the same edge as a write returns the pre-write value.
  assign rdata = vol_q[raddr];

endmodule

// File: rtl/tdm_voice_mixer.sv
// Three-stage scale-and-sum of a TDM voice stream; one mixed sample per frame.
module tdm_voice_mixer
  import synth_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst,
  tdm_voice_mixer_if.slave bus
);

  vol_t    vol_rd;
  s1_t     s1_q;
  s2_t     s2_q;
  prod_t   prod_c;
  acc_t    sum_c;
  acc_t    acc_q;
  logic    armed_q;
  sample_t mix_q;
  logic    valid_q;

  tdm_vol_regfile u_vol (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .we      (bus.vol_we),
    .waddr   (bus.vol_addr),
    .wdata   (bus.vol_data),
    .raddr   (bus.ch_num_in),
    .rdata   (vol_rd)
  );

  // S1: capture one slot every cycle together with its channel volume.
  // NOTE: state registers use non-blocking assignments so every stage samples the previous stage's old value at the same edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_q <= '0;
    end else begin
      s1_q <= '{vld: 1'b1, en: bus.ch_en_in, ch: bus.ch_num_in,
                sample: bus.sample_in, vol: vol_rd};
    end
  end

  // S2 datapath: scale the sample, forcing disabled slots to zero.
  // NOTE: the default assignment first means no path leaves prod_c unassigned, so no latch is inferred.
  always_comb begin
    prod_c = '0;
    if (s1_q.en) prod_c = prod_t'(s1_q.sample) * prod_t'(s1_q.vol);
  end

  // S2: register the product and carry the tag forward.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s2_q <= '0;
    end else begin
      s2_q <= '{vld: s1_q.vld, ch: s1_q.ch, prod: prod_c};
    end
  end

  // Running frame sum including the slot now in S2.
  always_comb begin
    sum_c = acc_q + acc_t'(s2_q.prod);
  end

  // S3: accumulate the frame; tag 0 opens it, the last tag emits it if it was opened.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      acc_q   <= '0;
      armed_q <= 1'b0;
      mix_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (s2_q.vld) begin
        if (s2_q.ch == '0) begin
          acc_q   <= acc_t'(s2_q.prod);
          armed_q <= 1'b1;
        end else if (is_last_ch(s2_q.ch)) begin
          if (armed_q) begin
            // Sum is below 2^ACC_W, so the truncated shift always fits D_W.
            mix_q   <= sample_t'(sum_c >> MIX_SHAMT);
            valid_q <= 1'b1;
          end
          acc_q   <= '0;
          armed_q <= 1'b0;
        end else begin
          acc_q <= sum_c;
        end
      end
    end
  end

  assign bus.mix_out   = mix_q;
  assign bus.mix_valid = valid_q;

endmodule
